// File: rtl/exe_lsu_req_if.sv
// Bus-side handshake between the load/store request engine and the data-SRAM-like bridge.
// The engine is the master; the bridge answers with addr_ok/data_ok/rdata.
interface exe_lsu_req_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic                  req;
    logic                  wr;
    logic [1:0]            size;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/exe_lsu_req.sv
// Load/store request engine: one held op, DEPTH outstanding bus requests, in-order
// responses with alignment, sign/zero extension and flush-based response suppression.
module exe_lsu_req #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              ale,
    input  logic              flush,
    exe_lsu_req_if.master     bus,
    output logic              resp_valid,
    output logic              resp_store,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              busy
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              store;
        logic [1:0]        size;
        logic              sgn;
        logic [ADDR_W-1:0] addr;
        logic [NB-1:0]     wstrb;
        logic [DATA_W-1:0] wdata;
        logic [TAG_W-1:0]  tag;
    } hold_t;

    typedef struct packed {
        logic             store;
        logic [1:0]       size;
        logic             sgn;
        logic [OFF_W-1:0] off;
        logic [TAG_W-1:0] tag;
    } meta_t;

    hold_t             hold_q, hold_d, new_hold;
    logic              hold_valid_q, hold_valid_d;
    logic              hold_killed_q, hold_killed_d;
    meta_t             fifo_q [DEPTH];
    meta_t             fifo_d [DEPTH];
    logic [DEPTH-1:0]  kill_q, kill_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_store_q, resp_store_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;

    logic              misaligned, accept, push, pop;
    logic [NB-1:0]     size_mask;
    logic [DATA_W-1:0] rep_wdata, shifted, ext;
    meta_t             popped;

    // Dword ops are only legal on a 64-bit bus.
    assign misaligned = (in_size == 2'd1 && in_addr[0]) ||
                        (in_size == 2'd2 && in_addr[1:0] != 2'b00) ||
                        (in_size == 2'd3 && (DATA_W == 32 || in_addr[2:0] != 3'b000));
    assign ale        = in_valid && misaligned;
    assign in_ready   = !hold_valid_q && (cnt_q < CNT_W'(DEPTH)) && !flush;
    assign accept     = in_valid && in_ready && !misaligned;
    assign push       = hold_valid_q && bus.addr_ok;
    assign pop        = bus.data_ok && (cnt_q != '0);
    assign popped     = fifo_q[rptr_q];

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        size_mask = '0;
        rep_wdata = '0;
        case (in_size)
            2'd0:    size_mask = NB'(8'h01);
            2'd1:    size_mask = NB'(8'h03);
            2'd2:    size_mask = NB'(8'h0F);
            default: size_mask = NB'(8'hFF);
        endcase
        for (int i = 0; i < NB; i++) begin
            case (in_size)
                2'd0:    rep_wdata[i*8 +: 8] = in_wdata[7:0];
                2'd1:    rep_wdata[i*8 +: 8] = in_wdata[(i % 2)*8 +: 8];
                2'd2:    rep_wdata[i*8 +: 8] = in_wdata[(i % 4)*8 +: 8];
                default: rep_wdata[i*8 +: 8] = in_wdata[i*8 +: 8];
            endcase
        end
        new_hold.store = in_store;
        new_hold.size  = in_size;
        new_hold.sgn   = in_signed;
        new_hold.addr  = in_addr;
        new_hold.wstrb = in_store ? (size_mask << in_addr[OFF_W-1:0]) : '0;
        new_hold.wdata = rep_wdata;
        new_hold.tag   = in_tag;
    end

    always_comb begin
        shifted = bus.rdata >> {popped.off, 3'b000};
        ext     = shifted;
        case (popped.size)
            2'd0: begin
                ext       = {DATA_W{popped.sgn & shifted[7]}};
                ext[7:0]  = shifted[7:0];
            end
            2'd1: begin
                ext       = {DATA_W{popped.sgn & shifted[15]}};
                ext[15:0] = shifted[15:0];
            end
            2'd2: begin
                ext       = {DATA_W{popped.sgn & shifted[31]}};
                ext[31:0] = shifted[31:0];
            end
            default: ext = shifted;
        endcase
    end

    always_comb begin
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        hold_killed_d = hold_killed_q | flush;
        fifo_d        = fifo_q;
        kill_d        = kill_q | {DEPTH{flush}};
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        cnt_d         = cnt_q;
        resp_valid_d  = 1'b0;
        resp_store_d  = resp_store_q;
        resp_data_d   = resp_data_q;
        resp_tag_d    = resp_tag_q;

        if (push) begin
            hold_valid_d   = 1'b0;
            fifo_d[wptr_q] = '{store: hold_q.store, size: hold_q.size, sgn: hold_q.sgn,
                               off: hold_q.addr[OFF_W-1:0], tag: hold_q.tag};
            kill_d[wptr_q] = hold_killed_q | flush;
            wptr_d         = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
        end
        if (accept) begin
            hold_d        = new_hold;
            hold_valid_d  = 1'b1;
            hold_killed_d = 1'b0;
        end
        // A flush arriving with data_ok suppresses the entry being popped.
        if (pop) begin
            rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
            if (!(kill_q[rptr_q] || flush)) begin
                resp_valid_d = 1'b1;
                resp_store_d = popped.store;
                resp_data_d  = popped.store ? '0 : ext;
                resp_tag_d   = popped.tag;
            end
        end
        if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
        if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end

    // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            hold_killed_q <= 1'b0;
            kill_q        <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            cnt_q         <= '0;
            resp_valid_q  <= 1'b0;
            resp_store_q  <= 1'b0;
            resp_data_q   <= '0;
            resp_tag_q    <= '0;
        end else begin
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            hold_killed_q <= hold_killed_d;
            kill_q        <= kill_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            cnt_q         <= cnt_d;
            resp_valid_q  <= resp_valid_d;
            resp_store_q  <= resp_store_d;
            resp_data_q   <= resp_data_d;
            resp_tag_q    <= resp_tag_d;
        end
    end

    // NOTE: FIFO payload is not reset; an entry is only read after a push has written it.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign bus.req    = hold_valid_q;
    assign bus.wr     = hold_q.store;
    assign bus.size   = hold_q.size;
    assign bus.addr   = hold_q.addr;
    assign bus.wstrb  = hold_q.wstrb;
    assign bus.wdata  = hold_q.wdata;
    assign resp_valid = resp_valid_q;
    assign resp_store = resp_store_q;
    assign resp_data  = resp_data_q;
    assign resp_tag   = resp_tag_q;
    assign busy       = hold_valid_q || (cnt_q != '0);
endmodule

// File: tb/tb_exe_lsu_req.sv
// Directed bench: a 32-bit/DEPTH=2 instance and a 64-bit/DEPTH=4 instance driven by
// hand-written vectors with hand-computed expected values.
module tb_exe_lsu_req;
    logic clk = 1'b0;
    logic rst;
    int   total, bad, seen;

    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_in_store, a_in_signed, a_ale, a_flush;
    logic        a_resp_valid, a_resp_store, a_busy;
    logic [1:0]  a_in_size;
    logic [31:0] a_in_addr, a_in_wdata, a_resp_data;
    logic [4:0]  a_in_tag, a_resp_tag;
    exe_lsu_req_if #(.DATA_W(32), .ADDR_W(32)) a_bus ();

    logic        b_in_valid, b_in_ready, b_in_store, b_in_signed, b_ale, b_flush;
    logic        b_resp_valid, b_resp_store, b_busy;
    logic [1:0]  b_in_size;
    logic [31:0] b_in_addr;
    logic [63:0] b_in_wdata, b_resp_data;
    logic [4:0]  b_in_tag, b_resp_tag;
    exe_lsu_req_if #(.DATA_W(64), .ADDR_W(32)) b_bus ();

    exe_lsu_req #(.DATA_W(32), .ADDR_W(32), .DEPTH(2), .TAG_W(5)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_store(a_in_store), .in_size(a_in_size), .in_signed(a_in_signed),
        .in_addr(a_in_addr), .in_wdata(a_in_wdata), .in_tag(a_in_tag), .ale(a_ale),
        .flush(a_flush), .bus(a_bus), .resp_valid(a_resp_valid), .resp_store(a_resp_store),
        .resp_data(a_resp_data), .resp_tag(a_resp_tag), .busy(a_busy)
    );

    exe_lsu_req #(.DATA_W(64), .ADDR_W(32), .DEPTH(4), .TAG_W(5)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_store(b_in_store), .in_size(b_in_size), .in_signed(b_in_signed),
        .in_addr(b_in_addr), .in_wdata(b_in_wdata), .in_tag(b_in_tag), .ale(b_ale),
        .flush(b_flush), .bus(b_bus), .resp_valid(b_resp_valid), .resp_store(b_resp_store),
        .resp_data(b_resp_data), .resp_tag(b_resp_tag), .busy(b_busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_issue(input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] tg);
        a_in_valid = 1'b1; a_in_store = st; a_in_size = sz; a_in_signed = sg;
        a_in_addr = ad; a_in_wdata = wd; a_in_tag = tg;
    endtask

    task automatic b_issue(input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [63:0] wd, input logic [4:0] tg);
        b_in_valid = 1'b1; b_in_store = st; b_in_size = sz; b_in_signed = sg;
        b_in_addr = ad; b_in_wdata = wd; b_in_tag = tg;
    endtask

    task automatic idle_all();
        a_in_valid = 0; a_in_store = 0; a_in_size = 0; a_in_signed = 0; a_in_addr = 0;
        a_in_wdata = 0; a_in_tag = 0; a_flush = 0;
        a_bus.addr_ok = 0; a_bus.data_ok = 0; a_bus.rdata = 0;
        b_in_valid = 0; b_in_store = 0; b_in_size = 0; b_in_signed = 0; b_in_addr = 0;
        b_in_wdata = 0; b_in_tag = 0; b_flush = 0;
        b_bus.addr_ok = 0; b_bus.data_ok = 0; b_bus.rdata = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%h exp=1", a_in_ready); end
        total++; if (a_bus.req !== 1'b0) begin bad++; $display("FAIL rst_req got=%h exp=0", a_bus.req); end
        total++; if (a_bus.wr !== 1'b0) begin bad++; $display("FAIL rst_wr got=%h exp=0", a_bus.wr); end
        total++; if (a_bus.wstrb !== 4'h0) begin bad++; $display("FAIL rst_wstrb got=%h exp=0", a_bus.wstrb); end
        total++; if (a_resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%h exp=0", a_resp_valid); end
        total++; if (a_resp_data !== 32'h0) begin bad++; $display("FAIL rst_resp_data got=%h exp=0", a_resp_data); end
        total++; if (a_resp_tag !== 5'h0) begin bad++; $display("FAIL rst_resp_tag got=%h exp=0", a_resp_tag); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%h exp=0", a_busy); end
        total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL rst_b_in_ready got=%h exp=1", b_in_ready); end
        total++; if (b_bus.req !== 1'b0) begin bad++; $display("FAIL rst_b_req got=%h exp=0", b_bus.req); end
    endtask

    task automatic test_word_load();
        a_issue(0, 2'd2, 1, 32'h1000, 32'h0, 5'd5);
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL wl_in_ready got=%h exp=1", a_in_ready); end
        total++; if (a_ale !== 1'b0) begin bad++; $display("FAIL wl_ale got=%h exp=0", a_ale); end
        cyc(); a_in_valid = 0;
        total++; if (a_bus.req !== 1'b1) begin bad++; $display("FAIL wl_req got=%h exp=1", a_bus.req); end
        total++; if (a_bus.wr !== 1'b0) begin bad++; $display("FAIL wl_wr got=%h exp=0", a_bus.wr); end
        total++; if (a_bus.addr !== 32'h1000) begin bad++; $display("FAIL wl_addr got=%h exp=1000", a_bus.addr); end
        total++; if (a_bus.size !== 2'd2) begin bad++; $display("FAIL wl_size got=%h exp=2", a_bus.size); end
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL wl_held_ready got=%h exp=0", a_in_ready); end
        a_bus.addr_ok = 1; cyc(); a_bus.addr_ok = 0;
        total++; if (a_bus.req !== 1'b0) begin bad++; $display("FAIL wl_req_drop got=%h exp=0", a_bus.req); end
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL wl_ready_back got=%h exp=1", a_in_ready); end
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL wl_busy got=%h exp=1", a_busy); end
        a_bus.data_ok = 1; a_bus.rdata = 32'h8000_00F0; cyc(); a_bus.data_ok = 0;
        total++; if (a_resp_valid !== 1'b1) begin bad++; $display("FAIL wl_resp_valid got=%h exp=1", a_resp_valid); end
        total++; if (a_resp_data !== 32'h8000_00F0) begin bad++; $display("FAIL wl_resp_data got=%h exp=800000f0", a_resp_data); end
        total++; if (a_resp_tag !== 5'd5) begin bad++; $display("FAIL wl_resp_tag got=%h exp=5", a_resp_tag); end
        total++; if (a_resp_store !== 1'b0) begin bad++; $display("FAIL wl_resp_store got=%h exp=0", a_resp_store); end
        cyc();
        total++; if (a_resp_valid !== 1'b0) begin bad++; $display("FAIL wl_pulse got=%h exp=0", a_resp_valid); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL wl_busy_end got=%h exp=0", a_busy); end
    endtask

    task automatic test_store_half();
        a_issue(1, 2'd0, 0, 32'h2003, 32'h0000_00AB, 5'd1);
        cyc(); a_in_valid = 0;
        total++; if (a_bus.wstrb !== 4'b1000) begin bad++; $display("FAIL sb_wstrb got=%h exp=8", a_bus.wstrb); end
        total++; if (a_bus.wdata !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wdata got=%h exp=abababab", a_bus.wdata); end
        total++; if (a_bus.size !== 2'd0) begin bad++; $display("FAIL sb_size got=%h exp=0", a_bus.size); end
        total++; if (a_bus.wr !== 1'b1) begin bad++; $display("FAIL sb_wr got=%h exp=1", a_bus.wr); end
        a_bus.addr_ok = 1; cyc(); a_bus.addr_ok = 0;
        a_bus.data_ok = 1; a_bus.rdata = 32'h1234_5678; cyc(); a_bus.data_ok = 0;
        total++; if (a_resp_valid !== 1'b1) begin bad++; $display("FAIL sb_resp_valid got=%h exp=1", a_resp_valid); end
        total++; if (a_resp_store !== 1'b1) begin bad++; $display("FAIL sb_resp_store got=%h exp=1", a_resp_store); end
        total++; if (a_resp_data !== 32'h0) begin bad++; $display("FAIL sb_resp_data got=%h exp=0", a_resp_data); end
        a_issue(0, 2'd1, 1, 32'h2002, 32'h0, 5'd2);
        cyc(); a_in_valid = 0;
        total++; if (a_bus.wstrb !== 4'h0) begin bad++; $display("FAIL hl_wstrb got=%h exp=0", a_bus.wstrb); end
        a_bus.addr_ok = 1; cyc(); a_bus.addr_ok = 0;
        a_bus.data_ok = 1; a_bus.rdata = 32'h8001_0000; cyc(); a_bus.data_ok = 0;
        total++; if (a_resp_data !== 32'hFFFF_8001) begin bad++; $display("FAIL hl_resp_data got=%h exp=ffff8001", a_resp_data); end
        total++; if (a_resp_tag !== 5'd2) begin bad++; $display("FAIL hl_resp_tag got=%h exp=2", a_resp_tag); end
        cyc();
    endtask

    task automatic test_misaligned();
        a_in_size = 2'd2; a_in_addr = 32'h1002; a_in_valid = 0;
        #1;
        total++; if (a_ale !== 1'b0) begin bad++; $display("FAIL ma_ale_novalid got=%h exp=0", a_ale); end
        a_issue(0, 2'd2, 0, 32'h1002, 32'h0, 5'd7);
        #1;
        total++; if (a_ale !== 1'b1) begin bad++; $display("FAIL ma_ale got=%h exp=1", a_ale); end
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL ma_in_ready got=%h exp=1", a_in_ready); end
        cyc();
        a_issue(0, 2'd3, 0, 32'h1000, 32'h0, 5'd8);
        #1;
        total++; if (a_ale !== 1'b1) begin bad++; $display("FAIL ma_dword32_ale got=%h exp=1", a_ale); end
        cyc(); a_in_valid = 0;
        total++; if (a_bus.req !== 1'b0) begin bad++; $display("FAIL ma_req got=%h exp=0", a_bus.req); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL ma_busy got=%h exp=0", a_busy); end
        seen = 0;
        repeat (3) begin cyc(); if (a_resp_valid || a_bus.req) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL ma_activity got=%0d exp=0", seen); end
    endtask

    task automatic test_back_to_back();
        a_issue(0, 2'd2, 0, 32'h100, 32'h0, 5'd1);
        cyc(); a_in_valid = 0; a_bus.addr_ok = 1;
        cyc(); a_bus.addr_ok = 0;
        a_issue(0, 2'd2, 0, 32'h104, 32'h0, 5'd2);
        cyc();
        a_issue(0, 2'd2, 0, 32'h108, 32'h0, 5'd3);
        a_bus.addr_ok = 1;
        cyc(); a_bus.addr_ok = 0;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bb_full_ready got=%h exp=0", a_in_ready); end
        total++; if (a_bus.req !== 1'b0) begin bad++; $display("FAIL bb_full_req got=%h exp=0", a_bus.req); end
        cyc();
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bb_full_ready2 got=%h exp=0", a_in_ready); end
        a_bus.data_ok = 1; a_bus.rdata = 32'h1111_1111;
        cyc(); a_bus.data_ok = 0;
        total++; if (a_resp_tag !== 5'd1 || a_resp_valid !== 1'b1) begin bad++; $display("FAIL bb_resp1 got=%h/%h exp=1/1", a_resp_valid, a_resp_tag); end
        total++; if (a_resp_data !== 32'h1111_1111) begin bad++; $display("FAIL bb_data1 got=%h exp=11111111", a_resp_data); end
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bb_freed_ready got=%h exp=1", a_in_ready); end
        cyc(); a_in_valid = 0;
        total++; if (a_bus.req !== 1'b1 || a_bus.addr !== 32'h108) begin bad++; $display("FAIL bb_req3 got=%h/%h exp=1/108", a_bus.req, a_bus.addr); end
        a_bus.addr_ok = 1; a_bus.data_ok = 1; a_bus.rdata = 32'h2222_2222;
        cyc(); a_bus.addr_ok = 0;
        total++; if (a_resp_tag !== 5'd2 || a_resp_data !== 32'h2222_2222) begin bad++; $display("FAIL bb_resp2 got=%h/%h exp=2/22222222", a_resp_tag, a_resp_data); end
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bb_ready_pp got=%h exp=1", a_in_ready); end
        a_bus.data_ok = 1; a_bus.rdata = 32'h3333_3333;
        cyc(); a_bus.data_ok = 0;
        total++; if (a_resp_valid !== 1'b1 || a_resp_tag !== 5'd3) begin bad++; $display("FAIL bb_resp3 got=%h/%h exp=1/3", a_resp_valid, a_resp_tag); end
        total++; if (a_resp_data !== 32'h3333_3333) begin bad++; $display("FAIL bb_data3 got=%h exp=33333333", a_resp_data); end
        cyc();
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL bb_busy got=%h exp=0", a_busy); end
        a_bus.data_ok = 1;
        cyc(); a_bus.data_ok = 0;
        total++; if (a_resp_valid !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL bb_stray_ack got=%h/%h exp=0/0", a_resp_valid, a_busy); end
    endtask

    task automatic test_flush_pop();
        a_issue(0, 2'd2, 0, 32'h400, 32'h0, 5'd9);
        cyc(); a_in_valid = 0; a_bus.addr_ok = 1;
        cyc(); a_bus.addr_ok = 0;
        a_flush = 1; a_bus.data_ok = 1; a_bus.rdata = 32'h5555_AAAA;
        a_issue(0, 2'd2, 0, 32'h404, 32'h0, 5'd10);
        #1;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL fp_ready got=%h exp=0", a_in_ready); end
        cyc(); a_flush = 0; a_bus.data_ok = 0; a_in_valid = 0;
        total++; if (a_resp_valid !== 1'b0) begin bad++; $display("FAIL fp_suppress got=%h exp=0", a_resp_valid); end
        total++; if (a_bus.req !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL fp_blocked got=%h/%h exp=0/0", a_bus.req, a_busy); end
        a_issue(0, 2'd2, 0, 32'h404, 32'h0, 5'd10);
        cyc(); a_in_valid = 0; a_bus.addr_ok = 1;
        cyc(); a_bus.addr_ok = 0; a_bus.data_ok = 1; a_bus.rdata = 32'h0BAD_F00D;
        cyc(); a_bus.data_ok = 0;
        total++; if (a_resp_valid !== 1'b1 || a_resp_tag !== 5'd10) begin bad++; $display("FAIL fp_after got=%h/%h exp=1/a", a_resp_valid, a_resp_tag); end
        total++; if (a_resp_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL fp_after_data got=%h exp=0badf00d", a_resp_data); end
        cyc();
    endtask

    task automatic test_flush_inflight();
        b_issue(0, 2'd3, 0, 32'h4000, 64'h0, 5'd1);
        cyc(); b_in_valid = 0; b_bus.addr_ok = 1;
        cyc(); b_bus.addr_ok = 0;
        b_issue(0, 2'd3, 0, 32'h4008, 64'h0, 5'd2);
        cyc(); b_in_valid = 0; b_bus.addr_ok = 1;
        cyc(); b_bus.addr_ok = 0;
        b_issue(1, 2'd3, 0, 32'h4010, 64'h1122_3344_5566_7788, 5'd3);
        cyc(); b_in_valid = 0;
        b_flush = 1;
        #1;
        total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got=%h exp=0", b_in_ready); end
        cyc(); b_flush = 0;
        total++; if (b_bus.req !== 1'b1 || b_bus.wr !== 1'b1) begin bad++; $display("FAIL fl_req_held got=%h/%h exp=1/1", b_bus.req, b_bus.wr); end
        total++; if (b_bus.wstrb !== 8'hFF) begin bad++; $display("FAIL fl_wstrb got=%h exp=ff", b_bus.wstrb); end
        total++; if (b_bus.wdata !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL fl_wdata got=%h exp=1122334455667788", b_bus.wdata); end
        cyc();
        total++; if (b_bus.req !== 1'b1) begin bad++; $display("FAIL fl_req_wait got=%h exp=1", b_bus.req); end
        b_bus.addr_ok = 1; cyc(); b_bus.addr_ok = 0;
        total++; if (b_bus.req !== 1'b0 || b_busy !== 1'b1) begin bad++; $display("FAIL fl_handshake got=%h/%h exp=0/1", b_bus.req, b_busy); end
        seen = 0;
        b_bus.data_ok = 1; b_bus.rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) begin cyc(); if (b_resp_valid) seen++; end
        b_bus.data_ok = 0;
        total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL fl_busy got=%h exp=0", b_busy); end
        cyc(); if (b_resp_valid) seen++;
        total++; if (seen !== 0) begin bad++; $display("FAIL fl_resp_count got=%0d exp=0", seen); end
    endtask

    task automatic test_dword();
        b_issue(0, 2'd3, 0, 32'h3004, 64'h0, 5'd0);
        #1;
        total++; if (b_ale !== 1'b1) begin bad++; $display("FAIL dw_mis_ale got=%h exp=1", b_ale); end
        b_issue(0, 2'd3, 0, 32'h3008, 64'h0, 5'd4);
        #1;
        total++; if (b_ale !== 1'b0) begin bad++; $display("FAIL dw_ale got=%h exp=0", b_ale); end
        cyc(); b_in_valid = 0;
        total++; if (b_bus.size !== 2'd3 || b_bus.addr !== 32'h3008) begin bad++; $display("FAIL dw_bus got=%h/%h exp=3/3008", b_bus.size, b_bus.addr); end
        b_bus.addr_ok = 1; cyc(); b_bus.addr_ok = 0;
        b_bus.data_ok = 1; b_bus.rdata = 64'hDEAD_BEEF_0123_4567; cyc(); b_bus.data_ok = 0;
        total++; if (b_resp_data !== 64'hDEAD_BEEF_0123_4567 || b_resp_tag !== 5'd4) begin bad++; $display("FAIL dw_resp got=%h/%h exp=deadbeef01234567/4", b_resp_data, b_resp_tag); end
        b_issue(0, 2'd0, 0, 32'h300F, 64'h0, 5'd5);
        cyc(); b_in_valid = 0; b_bus.addr_ok = 1;
        cyc(); b_bus.addr_ok = 0; b_bus.data_ok = 1; b_bus.rdata = 64'h9C00_0000_0000_00FF;
        cyc(); b_bus.data_ok = 0;
        total++; if (b_resp_data !== 64'h9C) begin bad++; $display("FAIL dw_byte_u got=%h exp=9c", b_resp_data); end
        b_issue(0, 2'd2, 1, 32'h3004, 64'h0, 5'd6);
        cyc(); b_in_valid = 0; b_bus.addr_ok = 1;
        cyc(); b_bus.addr_ok = 0; b_bus.data_ok = 1; b_bus.rdata = 64'h8765_4321_0000_0000;
        cyc(); b_bus.data_ok = 0;
        total++; if (b_resp_data !== 64'hFFFF_FFFF_8765_4321) begin bad++; $display("FAIL dw_word_s got=%h exp=ffffffff87654321", b_resp_data); end
        cyc();
    endtask

    task automatic test_reset_mid();
        b_issue(0, 2'd2, 0, 32'h5000, 64'h0, 5'd7);
        cyc(); b_in_valid = 0; b_bus.addr_ok = 1;
        cyc(); b_bus.addr_ok = 0;
        b_issue(1, 2'd0, 0, 32'h5001, 64'h55, 5'd8);
        cyc(); b_in_valid = 0; b_bus.addr_ok = 1;
        cyc(); b_bus.addr_ok = 0;
        total++; if (b_busy !== 1'b1) begin bad++; $display("FAIL rm_busy_pre got=%h exp=1", b_busy); end
        rst = 1; cyc(); rst = 0;
        total++; if (b_in_ready !== 1'b1 || b_busy !== 1'b0) begin bad++; $display("FAIL rm_ready_busy got=%h/%h exp=1/0", b_in_ready, b_busy); end
        total++; if (b_bus.req !== 1'b0 || b_bus.wr !== 1'b0) begin bad++; $display("FAIL rm_req_wr got=%h/%h exp=0/0", b_bus.req, b_bus.wr); end
        total++; if (b_bus.wstrb !== 8'h00) begin bad++; $display("FAIL rm_wstrb got=%h exp=0", b_bus.wstrb); end
        total++; if (b_resp_valid !== 1'b0 || b_resp_tag !== 5'd0) begin bad++; $display("FAIL rm_resp got=%h/%h exp=0/0", b_resp_valid, b_resp_tag); end
        total++; if (b_resp_data !== 64'h0) begin bad++; $display("FAIL rm_resp_data got=%h exp=0", b_resp_data); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_all();
        test_reset();
        test_word_load();
        test_store_half();
        test_misaligned();
        test_back_to_back();
        test_flush_pop();
        test_flush_inflight();
        test_dword();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
